// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter for the single-port data_mem: registered grant/command stage, read-return routing, lock bursts.
// Define DATA_MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic                    lock0,
  input  logic                    lock1,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  input  logic [2*DATA_WIDTH-1:0] wdata0,
  input  logic [2*DATA_WIDTH-1:0] wdata1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    rvalid0,
  output logic                    rvalid1,
  output logic [DATA_WIDTH-1:0]   rdata0,
  output logic [DATA_WIDTH-1:0]   rdata1,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_w_addr,
  output logic [ADDR_WIDTH-1:0]   mem_r_addr,
  output logic [2*DATA_WIDTH-1:0] mem_w_data,
  input  logic [DATA_WIDTH-1:0]   mem_r_data
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } owner_e;

  owner_e                  owner;
  logic                    pend_rd0;
  logic                    pend_rd1;
  logic                    elig0;
  logic                    elig1;
  logic                    win0;
  logic                    win1;
  logic                    sel_we;
  logic                    sel_lock;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [2*DATA_WIDTH-1:0] sel_wdata;

`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
  logic rr;
`endif

  // A requester showing gnt this cycle is still presenting the request just consumed.
  assign elig0 = req0 && !gnt0 && (owner != OWN_1);
  assign elig1 = req1 && !gnt1 && (owner != OWN_0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    win0 = 1'b0;
    win1 = 1'b0;
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    win0 = elig0;
    win1 = elig1 && !elig0;
`else
    if (!rr) begin
      win0 = elig0;
      win1 = elig1 && !elig0;
    end else begin
      win1 = elig1;
      win0 = elig0 && !elig1;
    end
`endif
  end

  assign sel_we    = win1 ? we1    : we0;
  assign sel_lock  = win1 ? lock1  : lock0;
  assign sel_addr  = win1 ? addr1  : addr0;
  assign sel_wdata = win1 ? wdata1 : wdata0;

  assign rdata0 = mem_r_data;
  assign rdata1 = mem_r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      pend_rd0   <= 1'b0;
      pend_rd1   <= 1'b0;
      mem_we     <= 1'b0;
      mem_w_addr <= '0;
      mem_r_addr <= '0;
      mem_w_data <= '0;
      owner      <= OWN_NONE;
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
      rr         <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      gnt0       <= win0;
      gnt1       <= win1;
      rvalid0    <= pend_rd0;
      rvalid1    <= pend_rd1;
      pend_rd0   <= win0 && !we0;
      pend_rd1   <= win1 && !we1;
      mem_we     <= (win0 || win1) && sel_we;
      mem_w_data <= '0;
      if (win0 || win1) begin
        if (sel_we) begin
          mem_w_addr <= sel_addr;
          mem_w_data <= sel_wdata;
        end else begin
          mem_r_addr <= sel_addr;
        end
        owner <= sel_lock ? (win1 ? OWN_1 : OWN_0) : OWN_NONE;
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
        // Pointer moves to the other requester, but is frozen during a locked burst.
        if (owner == OWN_NONE) rr <= win0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed steps plus randomized traffic against a transaction-level model.
// Honours DATA_MEM_ARB_FIXED_PRIO_EN the same way the design does.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_req   [2];
  logic        r_we    [2];
  logic        r_lock  [2];
  logic [7:0]  r_addr  [2];
  logic [15:0] r_wdata [2];
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [7:0]  rdata0, rdata1, mem_w_addr, mem_r_addr, mem_r_data;
  logic [15:0] mem_w_data;

  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic        mem_load;
  logic [7:0]  w_hi_addr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Transaction-level model state
  int          m_rr;
  int          m_own;  // 0 none, 1 owned by requester 0, 2 owned by requester 1
  bit          m_g [2];
  bit          m_we_e;
  logic [7:0]  m_waddr_e, m_raddr_e, m_cmd_data, m_rv_data, a1;
  logic [15:0] m_wdata_e;
  int          m_cmd_rd, m_rv, w;
  bit          e [2];

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(r_req[0]), .req1(r_req[1]),
    .we0(r_we[0]), .we1(r_we[1]),
    .lock0(r_lock[0]), .lock1(r_lock[1]),
    .addr0(r_addr[0]), .addr1(r_addr[1]),
    .wdata0(r_wdata[0]), .wdata1(r_wdata[1]),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  // Behavioural data_mem: synchronous read, two-byte write wrapping at the top address.
  assign w_hi_addr = mem_w_addr + 8'd1;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem[15] <= 8'h01;
    end else if (mem_we) begin
      mem[mem_w_addr] <= mem_w_data[7:0];
      mem[w_hi_addr]  <= mem_w_data[15:8];
    end
    mem_r_data <= mem[mem_r_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int x = 0; x < 2; x++) begin
      r_req[x] = 1'b0; r_we[x] = 1'b0; r_lock[x] = 1'b0;
      r_addr[x] = 8'h00; r_wdata[x] = 16'h0000;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt0"},   gnt0, 0);
    check({tag, "_gnt1"},   gnt1, 0);
    check({tag, "_rv0"},    rvalid0, 0);
    check({tag, "_rv1"},    rvalid1, 0);
    check({tag, "_we"},     mem_we, 0);
    check({tag, "_waddr"},  mem_w_addr, 0);
    check({tag, "_raddr"},  mem_r_addr, 0);
    check({tag, "_wdata"},  mem_w_data, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_load = 1'b1;
    rst = 1'b1;
    idle_all();
    step(); step();
    mem_load = 1'b0;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single read of address 0x0F
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 8'h0F;
    step();
    check("rd_gnt0", gnt0, 1);
    check("rd_gnt1", gnt1, 0);
    check("rd_raddr", mem_r_addr, 8'h0F);
    check("rd_we", mem_we, 0);
    r_req[0] = 1'b0;
    step();
    check("rd_rvalid0", rvalid0, 1);
    check("rd_rdata0", rdata0, 8'h01);
    check("rd_rvalid1", rvalid1, 0);
    check("rd_gnt0_off", gnt0, 0);

    // Write 0xBEEF at 0x20 from requester 1, then read back 0x21
    r_req[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 8'h20; r_wdata[1] = 16'hBEEF;
    step();
    check("wr_gnt1", gnt1, 1);
    check("wr_we", mem_we, 1);
    check("wr_waddr", mem_w_addr, 8'h20);
    check("wr_wdata", mem_w_data, 16'hBEEF);
    r_we[1] = 1'b0; r_addr[1] = 8'h21;
    step();
    check("wr_we_pulse", mem_we, 0);
    check("wr_gnt1_gap", gnt1, 0);
    check("wr_wdata_idle", mem_w_data, 0);
    step();
    check("rb_gnt1", gnt1, 1);
    check("rb_raddr", mem_r_addr, 8'h21);
    r_req[1] = 1'b0;
    step();
    check("rb_rvalid1", rvalid1, 1);
    check("rb_rdata1", rdata1, 8'hBE);
    check("rb_rvalid0", rvalid0, 0);

    // Contention from reset: grants alternate starting with requester 0
    rst = 1'b1; step(); rst = 1'b0;
    r_req[0] = 1'b1; r_addr[0] = 8'h03;
    r_req[1] = 1'b1; r_addr[1] = 8'h04;
    for (int i = 0; i < 6; i++) begin
      step();
      check("cont_gnt0", gnt0, (i % 2) == 0);
      check("cont_gnt1", gnt1, (i % 2) == 1);
    end
    idle_all();
    step(); step(); step();

    // Lock burst: three locked-then-unlocked reads by requester 0 while requester 1 waits
    rst = 1'b1; step(); rst = 1'b0;
    r_req[0] = 1'b1; r_lock[0] = 1'b1; r_addr[0] = 8'h01;
    r_req[1] = 1'b1; r_addr[1] = 8'h02;
    step();
    check("lk_gnt0_a", gnt0, 1); check("lk_gnt1_a", gnt1, 0);
    r_addr[0] = 8'h02;
    step();
    check("lk_gnt0_b", gnt0, 0); check("lk_gnt1_b", gnt1, 0);
    step();
    check("lk_gnt0_c", gnt0, 1); check("lk_gnt1_c", gnt1, 0);
    r_lock[0] = 1'b0; r_addr[0] = 8'h03;
    step();
    check("lk_gnt0_d", gnt0, 0); check("lk_gnt1_d", gnt1, 0);
    step();
    check("lk_gnt0_e", gnt0, 1); check("lk_gnt1_e", gnt1, 0);
    r_req[0] = 1'b0;
    step();
    check("lk_gnt1_f", gnt1, 1); check("lk_gnt0_f", gnt0, 0);
    idle_all();
    step(); step();

    // Top-address write wraps its high byte to address 0
    r_req[0] = 1'b1; r_we[0] = 1'b1; r_addr[0] = 8'hFF; r_wdata[0] = 16'h1234;
    step();
    check("wrap_gnt0", gnt0, 1);
    check("wrap_waddr", mem_w_addr, 8'hFF);
    check("wrap_wdata", mem_w_data, 16'h1234);
    idle_all();
    step();
    check("wrap_mem255", mem[255], 8'h34);
    check("wrap_mem0", mem[0], 8'h12);

    // Reset while a read command is on the memory port
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 8'h0F;
    step();
    check("rstrd_gnt0", gnt0, 1);
    rst = 1'b1; idle_all();
    step();
    check_reset_outputs("rstrd_a");
    rst = 1'b0;
    step();
    check_reset_outputs("rstrd_b");

    // Randomized traffic against the transaction-level model
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    m_rr = 0; m_own = 0; m_g[0] = 1'b0; m_g[1] = 1'b0;
    m_we_e = 1'b0; m_cmd_rd = -1; m_rv = -1;
    m_waddr_e = '0; m_raddr_e = '0; m_wdata_e = '0; m_cmd_data = '0; m_rv_data = '0;
    for (int k = 0; k < 600; k++) begin
      step();
      check("rnd_gnt0", gnt0, m_g[0]);
      check("rnd_gnt1", gnt1, m_g[1]);
      check("rnd_rvalid0", rvalid0, m_rv == 0);
      check("rnd_rvalid1", rvalid1, m_rv == 1);
      if (m_rv == 0) check("rnd_rdata0", rdata0, m_rv_data);
      if (m_rv == 1) check("rnd_rdata1", rdata1, m_rv_data);
      check("rnd_we", mem_we, m_we_e);
      if (m_g[0] || m_g[1]) begin
        if (m_we_e) begin
          check("rnd_waddr", mem_w_addr, m_waddr_e);
          check("rnd_wdata", mem_w_data, m_wdata_e);
        end else begin
          check("rnd_raddr", mem_r_addr, m_raddr_e);
        end
      end else begin
        check("rnd_wdata_idle", mem_w_data, 0);
      end

      // Requesters: hold a request until granted, then optionally issue a new one
      for (int x = 0; x < 2; x++) begin
        if (!r_req[x] || m_g[x]) begin
          r_req[x]   = ($urandom_range(0, 3) != 0);
          r_we[x]    = 1'($urandom_range(0, 1));
          r_lock[x]  = ($urandom_range(0, 3) == 0);
          r_addr[x]  = 8'($urandom);
          r_wdata[x] = 16'($urandom);
        end
      end

      // Who gets the memory next cycle
      e[0] = r_req[0] && !m_g[0] && (m_own != 2);
      e[1] = r_req[1] && !m_g[1] && (m_own != 1);
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
      w = e[0] ? 0 : (e[1] ? 1 : -1);
`else
      w = e[m_rr] ? m_rr : (e[1 - m_rr] ? 1 - m_rr : -1);
`endif
      m_rv = m_cmd_rd; m_rv_data = m_cmd_data;
      m_g[0] = 1'b0; m_g[1] = 1'b0; m_we_e = 1'b0; m_cmd_rd = -1;
      if (w >= 0) begin
        m_g[w] = 1'b1;
        m_we_e = r_we[w];
        if (r_we[w]) begin
          m_waddr_e = r_addr[w];
          m_wdata_e = r_wdata[w];
          a1 = r_addr[w] + 8'd1;
          ref_mem[r_addr[w]] = r_wdata[w][7:0];
          ref_mem[a1]        = r_wdata[w][15:8];
        end else begin
          m_raddr_e  = r_addr[w];
          m_cmd_rd   = w;
          m_cmd_data = ref_mem[r_addr[w]];
        end
        if (m_own == 0) m_rr = 1 - w;
        m_own = r_lock[w] ? w + 1 : 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
